ram_io_responder: RTL and testbench

RAM_IO_RESPONDER -- requirements
Module: ram_io_responder

---
 rtl/ram_io_responder.sv | 138 +++++++++++++
 tb/tb_ram_io_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ram_io_responder.sv
// Byte RAM with memory-mapped TX/RX byte FIFOs for a CPU memory controller.
// Ports: clk, rst (sync, high), rdy (global enable); mem_a/mem_wr/mem_dout in,
//   mem_din out (registered read byte); io_buffer_full (TX near-full);
//   tx_data/tx_valid/tx_ready (TX sink); rx_data/rx_valid/rx_ready (RX source);
//   sim_end (sticky program end); tx_ovf (sticky TX drop).
module ram_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        sim_end,
  output logic        tx_ovf
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [TAW:0] TX_CAP = (TAW+1)'(TX_DEPTH);
  localparam logic [TAW:0] TX_HI  = (TAW+1)'(TX_DEPTH - 2);
  localparam logic [RAW:0] RX_CAP = (RAW+1)'(RX_DEPTH);

  logic [7:0] ram    [2**ADDR_WIDTH];
  logic [7:0] tx_mem [TX_DEPTH];
  logic [7:0] rx_mem [RX_DEPTH];

  logic [TAW-1:0] tx_rd, tx_wr;
  logic [TAW:0]   tx_cnt, tx_cnt_nxt;
  logic [RAW-1:0] rx_rd, rx_wr;
  logic [RAW:0]   rx_cnt, rx_cnt_nxt;

  logic                  is_io;
  logic                  off_data;
  logic                  off_stat;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  tx_push_req;
  logic                  tx_full;
  logic                  tx_push;
  logic                  tx_pop;
  logic                  rx_nonempty;
  logic                  rx_push;
  logic                  rx_pop;
  logic                  end_wr;
  logic [7:0]            rd_byte;
  logic                  unused_bits;

  assign unused_bits = ^mem_a;

  assign is_io    = (mem_a[17:16] == 2'b11);
  assign off_data = (mem_a[15:0] == 16'h0000);
  assign off_stat = (mem_a[15:0] == 16'h0004);
  assign ram_addr = mem_a[ADDR_WIDTH-1:0];

  assign tx_full     = (tx_cnt == TX_CAP);
  assign tx_valid    = (tx_cnt != '0);
  assign tx_push_req = rdy & is_io & mem_wr & off_data;
  assign tx_push     = tx_push_req & ~tx_full;
  assign tx_pop      = tx_valid & tx_ready & rdy;
  assign tx_data     = tx_valid ? tx_mem[tx_rd] : 8'h00;

  assign rx_nonempty = (rx_cnt != '0);
  assign rx_ready    = rdy & (rx_cnt != RX_CAP);
  assign rx_push     = rx_valid & rx_ready;
  assign rx_pop      = rdy & is_io & ~mem_wr & off_data & rx_nonempty;

  assign end_wr = rdy & is_io & mem_wr & off_stat;

  always_comb begin
    tx_cnt_nxt = tx_cnt;
    if (tx_push) tx_cnt_nxt = tx_cnt_nxt + 1'b1;
    if (tx_pop)  tx_cnt_nxt = tx_cnt_nxt - 1'b1;
  end

  always_comb begin
    rx_cnt_nxt = rx_cnt;
    if (rx_push) rx_cnt_nxt = rx_cnt_nxt + 1'b1;
    if (rx_pop)  rx_cnt_nxt = rx_cnt_nxt - 1'b1;
  end

  // Read mux; an empty RX pop reads as zero even if a byte lands this edge.
  always_comb begin
    rd_byte = 8'h00;
    if (!is_io) begin
      rd_byte = ram[ram_addr];
    end else if (off_data) begin
      rd_byte = rx_nonempty ? rx_mem[rx_rd] : 8'h00;
    end else if (off_stat) begin
      rd_byte = {6'b0, io_buffer_full, rx_nonempty};
    end
  end

  // Storage arrays carry no reset; pointers decide what is live.
  always_ff @(posedge clk) begin
    if (rdy && mem_wr && !is_io) ram[ram_addr] <= mem_dout;
    if (tx_push) tx_mem[tx_wr] <= mem_dout;
    if (rx_push) rx_mem[rx_wr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_din        <= 8'h00;
      tx_rd          <= '0;
      tx_wr          <= '0;
      tx_cnt         <= '0;
      rx_rd          <= '0;
      rx_wr          <= '0;
      rx_cnt         <= '0;
      io_buffer_full <= 1'b0;
      sim_end        <= 1'b0;
      tx_ovf         <= 1'b0;
    end else if (rdy) begin
      if (!mem_wr) mem_din <= rd_byte;
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      tx_cnt <= tx_cnt_nxt;
      rx_cnt <= rx_cnt_nxt;
      // Two slots of slack cover the controller's check-to-store skew.
      io_buffer_full <= (tx_cnt_nxt >= TX_HI);
      if (end_wr) sim_end <= 1'b1;
      if (tx_push_req && tx_full) tx_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed self-checking bench for ram_io_responder.
// Drives and samples 1ns after each rising edge.
module tb_ram_io_responder;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        sim_end;
  logic        tx_ovf;

  int tests;
  int fails;

  ram_io_responder dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .sim_end(sim_end), .tx_ovf(tx_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    mem_a = a; mem_wr = 1'b1; mem_dout = d;
    tick();
  endtask

  task automatic rd(input logic [31:0] a);
    mem_a = a; mem_wr = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] strm [4];
    strm[0] = 8'h11; strm[1] = 8'h22; strm[2] = 8'h33; strm[3] = 8'h44;
    tests = 0; fails = 0;
    rst = 1'b1; rdy = 1'b1; mem_a = 32'h30008; mem_wr = 1'b0;
    mem_dout = 8'h00; tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_din", mem_din, 8'h00);
    chk("rst_txv", tx_valid, 1'b0);
    chk("rst_txd", tx_data, 8'h00);
    chk("rst_full", io_buffer_full, 1'b0);
    chk("rst_end", sim_end, 1'b0);
    chk("rst_ovf", tx_ovf, 1'b0);
    chk("rst_rxr", rx_ready, 1'b1);

    // RAM write then read
    wr(32'h10, 8'hA5);
    rd(32'h10);
    chk("ram_a5", mem_din, 8'hA5);
    // top of RAM (bits 17:16 = 01 is still RAM)
    wr(32'h1FFFF, 8'h77);
    rd(32'h1FFFF);
    chk("ram_top", mem_din, 8'h77);

    // streaming reads
    for (int i = 0; i < 4; i++) wr(32'h100 + i, strm[i]);
    for (int i = 0; i < 4; i++) begin
      rd(32'h100 + i);
      chk("stream", mem_din, strm[i]);
    end

    // unmapped IO offset
    wr(32'h30008, 8'hEE);
    rd(32'h30008);
    chk("io_other", mem_din, 8'h00);
    chk("io_other_txv", tx_valid, 1'b0);

    // TX fill, near-full, overflow
    for (int i = 0; i < 5; i++) wr(32'h30000, 8'(8'h80 + i));
    chk("tx_5_full", io_buffer_full, 1'b0);
    chk("tx_head", tx_data, 8'h80);
    wr(32'h30000, 8'h85);
    chk("tx_6_full", io_buffer_full, 1'b1);
    wr(32'h30000, 8'h86);
    wr(32'h30000, 8'h87);
    chk("tx_8_ovf", tx_ovf, 1'b0);
    wr(32'h30000, 8'h88);
    chk("tx_9_ovf", tx_ovf, 1'b1);
    rd(32'h30004);
    chk("stat_full", mem_din, 8'h02);
    mem_a = 32'h30008; mem_wr = 1'b0;
    tx_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("tx_valid", tx_valid, 1'b1);
      chk("tx_drain", tx_data, 8'(8'h80 + i));
      tick();
    end
    chk("tx_empty", tx_valid, 1'b0);
    chk("tx_unfull", io_buffer_full, 1'b0);
    chk("tx_ovf_sticky", tx_ovf, 1'b1);

    // RX path
    rx_valid = 1'b1; rx_data = 8'h41; tick();
    rx_data = 8'h42; tick();
    rx_valid = 1'b0;
    rd(32'h30004);
    chk("rx_stat", mem_din, 8'h01);
    rd(32'h30000);
    chk("rx_pop1", mem_din, 8'h41);
    rd(32'h30000);
    chk("rx_pop2", mem_din, 8'h42);
    rd(32'h30000);
    chk("rx_pop3", mem_din, 8'h00);
    // pop and push together on empty FIFO
    rx_valid = 1'b1; rx_data = 8'h55;
    rd(32'h30000);
    rx_valid = 1'b0;
    chk("rx_pp_empty", mem_din, 8'h00);
    rd(32'h30000);
    chk("rx_pp_next", mem_din, 8'h55);
    // fill RX to capacity
    mem_a = 32'h30008;
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'(8'hC0 + i);
      tick();
    end
    rx_valid = 1'b0;
    chk("rx_full", rx_ready, 1'b0);
    rd(32'h30000);
    chk("rx_full_pop", mem_din, 8'hC0);
    chk("rx_room", rx_ready, 1'b1);

    // sim_end and rdy freeze
    wr(32'h30004, 8'h00);
    chk("sim_end", sim_end, 1'b1);
    wr(32'h200, 8'h12);
    rd(32'h10);
    rdy = 1'b0;
    #1;
    chk("rxr_rdy0", rx_ready, 1'b0);
    wr(32'h200, 8'h99);
    wr(32'h30000, 8'h66);
    rd(32'h100);
    chk("din_hold", mem_din, 8'hA5);
    chk("tx_hold", tx_valid, 1'b0);
    rdy = 1'b1;
    rd(32'h200);
    chk("ram_frozen", mem_din, 8'h12);

    // reset mid-stream
    tx_ready = 1'b0;
    wr(32'h30000, 8'h01);
    mem_a = 32'h30008; mem_wr = 1'b0;
    rst = 1'b1; tick();
    rst = 1'b0;
    #1;
    chk("rst2_end", sim_end, 1'b0);
    chk("rst2_ovf", tx_ovf, 1'b0);
    chk("rst2_din", mem_din, 8'h00);
    chk("rst2_txv", tx_valid, 1'b0);
    rd(32'h30004);
    chk("rst2_stat", mem_din, 8'h00);
    rd(32'h10);
    chk("rst2_ram", mem_din, 8'hA5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
